// File: rtl/conv_mem_pkg.sv
// Shared constants, bank-select encodings and handshake FSM states for the CONV memory responder.
package conv_mem_pkg;
  localparam int DW        = 20;
  localparam int AW        = 12;
  localparam int L1_AW     = 10;
  localparam int NUM_BANKS = 4;

  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;

  typedef enum logic [1:0] {IDLE, HS, RUN, DONE} state_t;

  function automatic logic csel_valid(input logic [2:0] s);
    return (s >= CSEL_L0K0) && (s <= CSEL_L1K1);
  endfunction

  // Bank slot 0..3 for a valid csel code.
  function automatic logic [1:0] csel_idx(input logic [2:0] s);
    logic [2:0] t;
    t = s - 3'd1;
    return t[1:0];
  endfunction
endpackage

// File: rtl/conv_mem_bank.sv
// Single memory bank: sync write, async read for the engine, registered read for the host.
module conv_mem_bank #(
  parameter int DW  = 20,
  parameter int DAW = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [DAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [DAW-1:0] raddr,
  output logic [DW-1:0]  rdata,
  input  logic [DAW-1:0] hraddr,
  output logic [DW-1:0]  hrdata
);
  logic [DW-1:0] mem [2**DAW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Async read sees pre-write contents when written in the same cycle.
  assign rdata = mem[raddr];

  always_ff @(posedge clk or posedge reset)
    if (reset) hrdata <= '0;
    else       hrdata <= mem[hraddr];
endmodule

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV engine: image ROM, four csel banks, ready/busy handshake.
// Optional protocol checker and write counter enabled by defining CONV_MEM_PROTCHK_EN.
module conv_mem_responder
  import conv_mem_pkg::*;
#(
  parameter int DW            = conv_mem_pkg::DW,
  parameter int AW            = conv_mem_pkg::AW,
  parameter int L1_AW         = conv_mem_pkg::L1_AW,
  parameter int READY_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          img_we,
  input  logic [AW-1:0] img_waddr,
  input  logic [DW-1:0] img_wdata,
  input  logic [2:0]    host_rsel,
  input  logic [AW-1:0] host_raddr,
  output logic [DW-1:0] host_rdata,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  output logic          timeout
`ifdef CONV_MEM_PROTCHK_EN
  ,
  output logic          prot_err,
  output logic [AW:0]   wr_cnt
`endif
);
  localparam int CW = $clog2(READY_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] hs_cnt;
  logic          hs_expire;

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d   = state_q;
    hs_expire = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = HS;
      HS: begin
        if (busy) state_d = RUN;
        else if (hs_cnt == CW'(READY_TIMEOUT - 1)) begin
          state_d   = IDLE;
          hs_expire = 1'b1;
        end
      end
      RUN:     if (!busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hs_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      hs_cnt  <= (state_q == HS) ? hs_cnt + 1'b1 : '0;
      timeout <= timeout | hs_expire;
    end

  // Decoded from state so reset drops ready/done without waiting for a clock.
  assign ready = (state_q == HS);
  assign done  = (state_q == DONE);

  // Image bank: host-loaded only while idle.
  logic [DW-1:0] img_hrd_unused;
  conv_mem_bank #(.DW(DW), .DAW(AW)) u_img (
    .clk, .reset,
    .we(img_we && (state_q == IDLE)), .waddr(img_waddr), .wdata(img_wdata),
    .raddr(iaddr), .rdata(idata),
    .hraddr('0), .hrdata(img_hrd_unused)
  );

  logic       wr_vld, rd_vld, hs_vld;
  logic [1:0] wr_idx, rd_idx, hs_idx;
  logic [2:0] host_rsel_q;
  logic [NUM_BANKS-1:0][DW-1:0] bank_rd, bank_hrd;

  assign wr_vld = csel_valid(csel);
  assign rd_vld = wr_vld;
  assign wr_idx = csel_idx(csel);
  assign rd_idx = wr_idx;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam int BAW = (b < 2) ? AW : L1_AW;
    conv_mem_bank #(.DW(DW), .DAW(BAW)) u_bank (
      .clk, .reset,
      .we(cwr && wr_vld && (wr_idx == 2'(b))),
      .waddr(caddr_wr[BAW-1:0]), .wdata(cdata_wr),
      .raddr(caddr_rd[BAW-1:0]), .rdata(bank_rd[b]),
      .hraddr(host_raddr[BAW-1:0]), .hrdata(bank_hrd[b])
    );
  end

  assign cdata_rd = (crd && rd_vld) ? bank_rd[rd_idx] : '0;

  // Bank data is already registered; the select is delayed to line up with it.
  always_ff @(posedge clk or posedge reset)
    if (reset) host_rsel_q <= 3'b000;
    else       host_rsel_q <= host_rsel;

  assign hs_vld     = csel_valid(host_rsel_q);
  assign hs_idx     = csel_idx(host_rsel_q);
  assign host_rdata = hs_vld ? bank_hrd[hs_idx] : '0;

`ifdef CONV_MEM_PROTCHK_EN
  logic wr_l1, rd_l1, viol;
  assign wr_l1 = (csel == CSEL_L1K0) || (csel == CSEL_L1K1);
  assign rd_l1 = wr_l1;

  always_comb begin
    viol = 1'b0;
    if ((cwr || crd) && !wr_vld)                  viol = 1'b1;
    if (cwr && wr_l1 && |caddr_wr[AW-1:L1_AW])    viol = 1'b1;
    if (crd && rd_l1 && |caddr_rd[AW-1:L1_AW])    viol = 1'b1;
    if (cwr && crd)                               viol = 1'b1;
    if (img_we && (state_q != IDLE))              viol = 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prot_err <= 1'b0;
      wr_cnt   <= '0;
    end else begin
      prot_err <= prot_err | viol;
      if (start && (state_q == IDLE)) wr_cnt <= '0;
      else if (cwr && wr_vld)         wr_cnt <= wr_cnt + 1'b1;
    end
`endif
endmodule
